// File: rtl/vproj_segmenter.sv
// Column/row occupancy projection of a binary frame, scanned after vsync fall
// into up to MAX_SEG horizontal segments plus the vertical extent.

module vproj_seg_slot (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        wr,
  input  logic        pub,
  input  logic [11:0] beg,
  input  logic [11:0] fin,
  output logic [11:0] seg_l,
  output logic [11:0] seg_r
);
  logic [11:0] work_l, work_r;

  // Working copy is filled during the column scan; the public copy only moves on publish.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      work_l <= '0;
      work_r <= '0;
      seg_l  <= '0;
      seg_r  <= '0;
    end else begin
      if (clr) begin
        work_l <= '0;
        work_r <= '0;
      end else if (wr) begin
        work_l <= beg;
        work_r <= fin;
      end
      if (pub) begin
        seg_l <= work_l;
        seg_r <= work_r;
      end
    end
  end
endmodule

module vproj_segmenter #(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int IMG_WIDTH_DATA = 8,
  parameter int MAX_SEG        = 8,
  parameter int BORDER         = 6,
  parameter int MIN_WIDTH      = 1,
  parameter int FG_ZERO        = 1
) (
  input  logic                      pixelclk,
  input  logic                      reset_n,
  input  logic [IMG_WIDTH_DATA-1:0] i_binary,
  input  logic                      i_hs,
  input  logic                      i_vs,
  input  logic                      i_de,
  input  logic [11:0]               i_hcount,
  input  logic [11:0]               i_vcount,
  output logic [12*MAX_SEG-1:0]     o_seg_l,
  output logic [12*MAX_SEG-1:0]     o_seg_r,
  output logic [4:0]                o_seg_cnt,
  output logic                      o_overflow,
  output logic [11:0]               o_vtop,
  output logic [11:0]               o_vbot,
  output logic                      o_valid,
  output logic                      o_busy
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [11:0] W_LAST = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] H_LAST = 12'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {WAIT_VS, ACCUM, SCAN_H, SCAN_V, DONE} state_t;
  state_t state_q, state_d;

  logic                  vs_r, vs_rise, vs_fall;
  logic [IMG_WIDTH-1:0]  colflag;
  logic [IMG_HEIGHT-1:0] rowflag;
  logic [11:0]           idx;
  logic                  prev;
  logic [11:0]           run_start;
  logic [4:0]            work_cnt;
  logic                  work_ovf;
  logic                  vfound;
  logic [11:0]           vtop_w, vbot_w;

  logic                  pix_on, fg;
  logic                  cflag, rflag, h_last, v_last;
  logic                  scan_clr, publish;
  logic                  run_close, run_ok, seg_store, seg_drop;
  logic [11:0]           run_beg, run_end;
  logic [12:0]           run_len;
  logic [11:0]           vtop_nx, vbot_nx;
  logic [MAX_SEG-1:0]    slot_wr;
  logic [MAX_SEG-1:0][11:0] seg_l, seg_r;
  logic                  unused_hs;

  assign unused_hs = i_hs;
  assign vs_rise   = i_vs & ~vs_r;
  assign vs_fall   = ~i_vs & vs_r;

  assign pix_on = (FG_ZERO != 0) ? (i_binary == '0) : (i_binary != '0);
  // Range check before indexing so out-of-range counts never alias onto a flag.
  assign fg = i_de && pix_on &&
              ({1'b0, i_hcount} >= 13'(BORDER)) && ({1'b0, i_hcount} < 13'(IMG_WIDTH)) &&
              ({1'b0, i_vcount} >= 13'(BORDER)) && ({1'b0, i_vcount} < 13'(IMG_HEIGHT));

  assign cflag  = colflag[idx[CW-1:0]];
  assign rflag  = rowflag[idx[RW-1:0]];
  assign h_last = (idx == W_LAST);
  assign v_last = (idx == H_LAST);

  always_comb begin
    state_d  = state_q;
    scan_clr = 1'b0;
    case (state_q)
      WAIT_VS: if (vs_rise) state_d = ACCUM;
      ACCUM: begin
        if (vs_fall) begin
          state_d  = SCAN_H;
          scan_clr = 1'b1;
        end
      end
      SCAN_H:  if (h_last) state_d = SCAN_V;
      SCAN_V:  if (v_last) state_d = DONE;
      DONE:    state_d = WAIT_VS;
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_VS;
    else          state_q <= state_d;
  end

  // A run closes on a 1->0 transition, or is forced closed at the last column.
  always_comb begin
    run_close = (state_q == SCAN_H) && ((!cflag && prev) || (cflag && h_last));
    run_end   = cflag ? idx : (idx - 12'd1);
    run_beg   = (cflag && !prev) ? idx : run_start;
    run_len   = {1'b0, run_end} - {1'b0, run_beg} + 13'd1;
    run_ok    = run_close && (run_len >= 13'(MIN_WIDTH));
    seg_store = run_ok && (work_cnt < 5'(MAX_SEG));
    seg_drop  = run_ok && !(work_cnt < 5'(MAX_SEG));
    publish   = (state_q == SCAN_V) && v_last;
    vtop_nx   = (rflag && !vfound) ? idx : vtop_w;
    vbot_nx   = rflag ? idx : vbot_w;
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_r       <= 1'b0;
      colflag    <= '0;
      rowflag    <= '0;
      idx        <= '0;
      prev       <= 1'b0;
      run_start  <= '0;
      work_cnt   <= '0;
      work_ovf   <= 1'b0;
      vfound     <= 1'b0;
      vtop_w     <= '0;
      vbot_w     <= '0;
      o_seg_cnt  <= '0;
      o_overflow <= 1'b0;
      o_vtop     <= '0;
      o_vbot     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      vs_r    <= i_vs;
      o_valid <= publish;
      o_busy  <= (state_d != ACCUM);

      if (state_q == ACCUM && fg) begin
        colflag[i_hcount[CW-1:0]] <= 1'b1;
        rowflag[i_vcount[RW-1:0]] <= 1'b1;
      end

      if (scan_clr) begin
        idx       <= '0;
        prev      <= 1'b0;
        run_start <= '0;
        work_cnt  <= '0;
        work_ovf  <= 1'b0;
        vfound    <= 1'b0;
        vtop_w    <= '0;
        vbot_w    <= '0;
      end

      // Clearing each flag as it is read leaves both arrays empty for the next frame.
      if (state_q == SCAN_H) begin
        colflag[idx[CW-1:0]] <= 1'b0;
        prev <= cflag;
        idx  <= h_last ? 12'd0 : idx + 12'd1;
        if (cflag && !prev) run_start <= idx;
        if (seg_store)      work_cnt  <= work_cnt + 5'd1;
        if (seg_drop)       work_ovf  <= 1'b1;
      end

      if (state_q == SCAN_V) begin
        rowflag[idx[RW-1:0]] <= 1'b0;
        idx <= v_last ? 12'd0 : idx + 12'd1;
        if (rflag) begin
          vbot_w <= idx;
          if (!vfound) begin
            vtop_w <= idx;
            vfound <= 1'b1;
          end
        end
      end

      if (publish) begin
        o_seg_cnt  <= work_cnt;
        o_overflow <= work_ovf;
        o_vtop     <= vtop_nx;
        o_vbot     <= vbot_nx;
      end
    end
  end

  for (genvar k = 0; k < MAX_SEG; k++) begin : g_slot
    assign slot_wr[k] = seg_store && (work_cnt == 5'(k));
    vproj_seg_slot u_slot (
      .pixelclk (pixelclk),
      .reset_n  (reset_n),
      .clr      (scan_clr),
      .wr       (slot_wr[k]),
      .pub      (publish),
      .beg      (run_beg),
      .fin      (run_end),
      .seg_l    (seg_l[k]),
      .seg_r    (seg_r[k])
    );
  end

  assign o_seg_l = seg_l;
  assign o_seg_r = seg_r;
endmodule

// File: tb/tb_vproj_segmenter.sv
// Directed bench for vproj_segmenter: default instance plus a MIN_WIDTH=2 instance on shared inputs.

module tb_vproj_segmenter;
  logic        pixelclk = 1'b0;
  logic        reset_n  = 1'b0;
  logic [7:0]  i_binary = 8'hFF;
  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [11:0] i_hcount = '0, i_vcount = '0;

  logic [95:0] o_seg_l, o_seg_r, m_seg_l, m_seg_r;
  logic [4:0]  o_seg_cnt, m_seg_cnt;
  logic        o_overflow, o_valid, o_busy, m_overflow, m_valid, m_busy;
  logic [11:0] o_vtop, o_vbot, m_vtop, m_vbot;

  int vectors = 0;
  int miscompares = 0;

  always #5 pixelclk = ~pixelclk;

  vproj_segmenter dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_binary(i_binary), .i_hs(i_hs), .i_vs(i_vs),
    .i_de(i_de), .i_hcount(i_hcount), .i_vcount(i_vcount), .o_seg_l(o_seg_l), .o_seg_r(o_seg_r),
    .o_seg_cnt(o_seg_cnt), .o_overflow(o_overflow), .o_vtop(o_vtop), .o_vbot(o_vbot),
    .o_valid(o_valid), .o_busy(o_busy));

  vproj_segmenter #(.MIN_WIDTH(2)) dut2 (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_binary(i_binary), .i_hs(i_hs), .i_vs(i_vs),
    .i_de(i_de), .i_hcount(i_hcount), .i_vcount(i_vcount), .o_seg_l(m_seg_l), .o_seg_r(m_seg_r),
    .o_seg_cnt(m_seg_cnt), .o_overflow(m_overflow), .o_vtop(m_vtop), .o_vbot(m_vbot),
    .o_valid(m_valid), .o_busy(m_busy));

  task automatic px(input int h, input int v, input logic [7:0] b);
    i_hcount = 12'(h); i_vcount = 12'(v); i_binary = b; i_de = 1'b1;
    @(posedge pixelclk); #1;
    i_de = 1'b0; i_binary = 8'hFF;
  endtask

  task automatic box(input int l, input int r, input int t, input int b);
    for (int v = t; v <= b; v++)
      for (int h = l; h <= r; h++) px(h, v, 8'h00);
  endtask

  task automatic frame_open();
    @(posedge pixelclk); #1;
    i_vs = 1'b1;
    @(posedge pixelclk); #1;
  endtask

  // Drops vs, then counts clocks from the fall edge to o_valid; 0 means it never came.
  task automatic frame_close_wait(output int n);
    i_vs = 1'b0;
    @(posedge pixelclk);
    n = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge pixelclk);
      if (o_valid) begin n = c; break; end
      @(posedge pixelclk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pixelclk);
    vectors++; if (o_valid !== 1'b0)    begin miscompares++; $display("FAIL rst_valid got %0b want 0", o_valid); end
    vectors++; if (o_seg_cnt !== 5'd0)  begin miscompares++; $display("FAIL rst_cnt got %0d want 0", o_seg_cnt); end
    vectors++; if (o_seg_l !== 96'd0)   begin miscompares++; $display("FAIL rst_seg_l got %h want 0", o_seg_l); end
    vectors++; if (o_seg_r !== 96'd0)   begin miscompares++; $display("FAIL rst_seg_r got %h want 0", o_seg_r); end
    vectors++; if (o_vtop !== 12'd0 || o_vbot !== 12'd0) begin miscompares++; $display("FAIL rst_v got %0d/%0d want 0/0", o_vtop, o_vbot); end
    vectors++; if (o_overflow !== 1'b0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_ovf_busy got %0b/%0b want 0/0", o_overflow, o_busy); end
    @(posedge pixelclk); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge pixelclk);
    vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL idle_busy got %0b want 1", o_busy); end
  endtask

  task automatic test_single_box();
    int n;
    logic [95:0] el, er;
    el = '0; er = '0; el[11:0] = 12'd100; er[11:0] = 12'd119;
    frame_open();
    box(100, 119, 50, 59);
    px(300, 200, 8'h01);
    px(120, 60, 8'hFF);
    frame_close_wait(n);
    vectors++; if (n !== 1121)          begin miscompares++; $display("FAIL box_latency got %0d want 1121", n); end
    vectors++; if (o_seg_cnt !== 5'd1)  begin miscompares++; $display("FAIL box_cnt got %0d want 1", o_seg_cnt); end
    vectors++; if (o_seg_l !== el)      begin miscompares++; $display("FAIL box_seg_l got %h want %h", o_seg_l, el); end
    vectors++; if (o_seg_r !== er)      begin miscompares++; $display("FAIL box_seg_r got %h want %h", o_seg_r, er); end
    vectors++; if (o_vtop !== 12'd50 || o_vbot !== 12'd59) begin miscompares++; $display("FAIL box_v got %0d/%0d want 50/59", o_vtop, o_vbot); end
    vectors++; if (o_overflow !== 1'b0) begin miscompares++; $display("FAIL box_ovf got %0b want 0", o_overflow); end
    vectors++; if (m_seg_cnt !== 5'd1)  begin miscompares++; $display("FAIL box_cnt_mw2 got %0d want 1", m_seg_cnt); end
    @(negedge pixelclk);
    vectors++; if (o_valid !== 1'b0)    begin miscompares++; $display("FAIL box_pulse_len got %0b want 0", o_valid); end
    vectors++; if (o_seg_cnt !== 5'd1)  begin miscompares++; $display("FAIL box_hold got %0d want 1", o_seg_cnt); end
  endtask

  task automatic test_border();
    int n;
    frame_open();
    px(3, 100, 8'h00); px(100, 3, 8'h00); px(5, 5, 8'h00);
    px(700, 100, 8'h00); px(100, 480, 8'h00); px(640, 50, 8'h00);
    frame_close_wait(n);
    vectors++; if (n !== 1121)         begin miscompares++; $display("FAIL border_latency got %0d want 1121", n); end
    vectors++; if (o_seg_cnt !== 5'd0) begin miscompares++; $display("FAIL border_cnt got %0d want 0", o_seg_cnt); end
    vectors++; if (o_seg_l !== 96'd0)  begin miscompares++; $display("FAIL border_seg_l got %h want 0", o_seg_l); end
    vectors++; if (o_vtop !== 12'd0 || o_vbot !== 12'd0) begin miscompares++; $display("FAIL border_v got %0d/%0d want 0/0", o_vtop, o_vbot); end
  endtask

  task automatic test_min_width();
    int n;
    logic [95:0] el, er, ml, mr;
    el = '0; er = '0; ml = '0; mr = '0;
    el[11:0] = 12'd10; el[23:12] = 12'd30;  el[35:24] = 12'd630;
    er[11:0] = 12'd19; er[23:12] = 12'd30;  er[35:24] = 12'd639;
    ml[11:0] = 12'd10; ml[23:12] = 12'd630;
    mr[11:0] = 12'd19; mr[23:12] = 12'd639;
    frame_open();
    box(10, 19, 100, 100);
    px(30, 100, 8'h00);
    box(630, 639, 100, 100);
    frame_close_wait(n);
    vectors++; if (m_seg_cnt !== 5'd2) begin miscompares++; $display("FAIL mw_cnt got %0d want 2", m_seg_cnt); end
    vectors++; if (m_seg_l !== ml)     begin miscompares++; $display("FAIL mw_seg_l got %h want %h", m_seg_l, ml); end
    vectors++; if (m_seg_r !== mr)     begin miscompares++; $display("FAIL mw_seg_r got %h want %h", m_seg_r, mr); end
    vectors++; if (o_seg_cnt !== 5'd3) begin miscompares++; $display("FAIL mw1_cnt got %0d want 3", o_seg_cnt); end
    vectors++; if (o_seg_l !== el || o_seg_r !== er) begin miscompares++; $display("FAIL mw1_segs got %h/%h want %h/%h", o_seg_l, o_seg_r, el, er); end
    vectors++; if (m_vtop !== 12'd100 || m_vbot !== 12'd100) begin miscompares++; $display("FAIL mw_v got %0d/%0d want 100/100", m_vtop, m_vbot); end
  endtask

  task automatic test_overflow();
    int n;
    logic [95:0] el, er;
    el = '0; er = '0;
    for (int k = 0; k < 8; k++) begin
      el[12*k +: 12] = 12'(20 + 20*k);
      er[12*k +: 12] = 12'(24 + 20*k);
    end
    frame_open();
    for (int j = 0; j < 10; j++) box(20 + 20*j, 24 + 20*j, 200, 200);
    frame_close_wait(n);
    vectors++; if (o_seg_cnt !== 5'd8)  begin miscompares++; $display("FAIL ovf_cnt got %0d want 8", o_seg_cnt); end
    vectors++; if (o_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b want 1", o_overflow); end
    vectors++; if (o_seg_l !== el)      begin miscompares++; $display("FAIL ovf_seg_l got %h want %h", o_seg_l, el); end
    vectors++; if (o_seg_r !== er)      begin miscompares++; $display("FAIL ovf_seg_r got %h want %h", o_seg_r, er); end
    frame_open();
    frame_close_wait(n);
    vectors++; if (n !== 1121)          begin miscompares++; $display("FAIL empty_latency got %0d want 1121", n); end
    vectors++; if (o_seg_cnt !== 5'd0 || o_overflow !== 1'b0) begin miscompares++; $display("FAIL empty_cnt_ovf got %0d/%0b want 0/0", o_seg_cnt, o_overflow); end
    vectors++; if (o_seg_l !== 96'd0 || o_seg_r !== 96'd0) begin miscompares++; $display("FAIL empty_slots got %h/%h want 0/0", o_seg_l, o_seg_r); end
    vectors++; if (o_vtop !== 12'd0 || o_vbot !== 12'd0) begin miscompares++; $display("FAIL empty_v got %0d/%0d want 0/0", o_vtop, o_vbot); end
  endtask

  task automatic test_back_to_back();
    int n, pulses, first;
    frame_open();
    box(200, 209, 300, 300);
    i_vs = 1'b0;
    @(posedge pixelclk);
    pulses = 0; first = 0;
    for (int c = 1; c <= 1300; c++) begin
      @(negedge pixelclk);
      if (o_valid) begin pulses++; if (first == 0) first = c; end
      @(posedge pixelclk); #1;
      i_vs = (c >= 100 && c < 104);
      if (c == 101) begin
        i_hcount = 12'd400; i_vcount = 12'd400; i_binary = 8'h00; i_de = 1'b1;
      end else begin
        i_de = 1'b0; i_binary = 8'hFF;
      end
    end
    vectors++; if (pulses !== 1)  begin miscompares++; $display("FAIL drop_pulses got %0d want 1", pulses); end
    vectors++; if (first !== 1121) begin miscompares++; $display("FAIL drop_latency got %0d want 1121", first); end
    vectors++; if (o_seg_cnt !== 5'd1 || o_seg_l[11:0] !== 12'd200 || o_seg_r[11:0] !== 12'd209) begin
      miscompares++; $display("FAIL drop_seg got %0d (%0d,%0d) want 1 (200,209)", o_seg_cnt, o_seg_l[11:0], o_seg_r[11:0]); end
    frame_open();
    box(500, 504, 10, 12);
    frame_close_wait(n);
    vectors++; if (n !== 1121) begin miscompares++; $display("FAIL next_latency got %0d want 1121", n); end
    vectors++; if (o_seg_cnt !== 5'd1 || o_seg_l[11:0] !== 12'd500 || o_seg_r[11:0] !== 12'd504) begin
      miscompares++; $display("FAIL next_seg got %0d (%0d,%0d) want 1 (500,504)", o_seg_cnt, o_seg_l[11:0], o_seg_r[11:0]); end
    vectors++; if (o_vtop !== 12'd10 || o_vbot !== 12'd12) begin miscompares++; $display("FAIL next_v got %0d/%0d want 10/12", o_vtop, o_vbot); end
  endtask

  task automatic test_reset_mid_scan();
    int n, pulses;
    frame_open();
    box(50, 59, 400, 400);
    i_vs = 1'b0;
    @(posedge pixelclk);
    repeat (800) @(posedge pixelclk);
    #1 reset_n = 1'b0;
    @(negedge pixelclk);
    vectors++; if (o_seg_cnt !== 5'd0 || o_seg_l !== 96'd0 || o_seg_r !== 96'd0) begin
      miscompares++; $display("FAIL mid_rst_segs got %0d %h %h want 0", o_seg_cnt, o_seg_l, o_seg_r); end
    vectors++; if (o_vtop !== 12'd0 || o_vbot !== 12'd0 || o_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_v got %0d/%0d/%0b want 0/0/0", o_vtop, o_vbot, o_valid); end
    @(posedge pixelclk); #1 reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 1300; c++) begin
      @(negedge pixelclk);
      if (o_valid) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL mid_rst_pulses got %0d want 0", pulses); end
    frame_open();
    box(70, 79, 30, 31);
    frame_close_wait(n);
    vectors++; if (n !== 1121) begin miscompares++; $display("FAIL post_rst_latency got %0d want 1121", n); end
    vectors++; if (o_seg_cnt !== 5'd1 || o_seg_l[11:0] !== 12'd70 || o_seg_r[11:0] !== 12'd79) begin
      miscompares++; $display("FAIL post_rst_seg got %0d (%0d,%0d) want 1 (70,79)", o_seg_cnt, o_seg_l[11:0], o_seg_r[11:0]); end
    vectors++; if (o_vtop !== 12'd30 || o_vbot !== 12'd31) begin miscompares++; $display("FAIL post_rst_v got %0d/%0d want 30/31", o_vtop, o_vbot); end
  endtask

  initial begin
    test_reset();
    test_single_box();
    test_border();
    test_min_width();
    test_overflow();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1);
  end
endmodule

// File: doc/vproj_segmenter.md
Name: vproj_segmenter

Overview:
- Parametrised successor of the fixed 8-character projection block.
- Builds column and row occupancy projections of a binary frame in internal flag registers, with no external RAM.
- After frame end, scans the projections and reports up to MAX_SEG horizontal segments (left/right columns) plus the vertical extent.
- Sits after the binarisation stage and feeds the character-box overlay/crop logic. One result set per frame, no 5-frame cycle.

Parameters:
- IMG_WIDTH, 640, active columns; column flag array depth.
- IMG_HEIGHT, 480, active rows; row flag array depth.
- IMG_WIDTH_DATA, 8, width of i_binary.
- MAX_SEG, 8, maximum number of stored segments (1..16).
- BORDER, 6, pixels with hcount<BORDER or vcount<BORDER are ignored.
- MIN_WIDTH, 1, runs narrower than this many columns are discarded.
- FG_ZERO, 1, 1: pixel==0 is foreground; 0: pixel!=0 is foreground.

Ports:
- pixelclk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- i_binary  in  IMG_WIDTH_DATA  binarised pixel
- i_hs  in  1  hsync (unused, reserved)
- i_vs  in  1  vsync; high during frame, falling edge = frame end
- i_de  in  1  data enable
- i_hcount  in  12  current column
- i_vcount  in  12  current row
- o_seg_l  out  12*MAX_SEG  packed left columns, segment k at [12k+11:12k]
- o_seg_r  out  12*MAX_SEG  packed right columns, same packing
- o_seg_cnt  out  5  number of valid stored segments (0..MAX_SEG)
- o_overflow  out  1  more than MAX_SEG qualifying segments found
- o_vtop  out  12  first foreground row
- o_vbot  out  12  last foreground row
- o_valid  out  1  one-cycle pulse: result buses updated
- o_busy  out  1  high while not in ACCUM

Behaviour:
- Reset: all outputs 0; colflag/rowflag all 0; state WAIT_VS; vs_r=0.
- vs_r registers i_vs. Rise = i_vs & !vs_r; fall = !i_vs & vs_r.
- States: WAIT_VS -> ACCUM on rise; ACCUM -> SCAN_H on fall; SCAN_H -> SCAN_V after index IMG_WIDTH-1; SCAN_V -> DONE after index IMG_HEIGHT-1; DONE -> WAIT_VS.
- Accumulation happens in ACCUM only.
  - A pixel is foreground when i_de=1 and BORDER<=hcount<IMG_WIDTH and BORDER<=vcount<IMG_HEIGHT and the FG_ZERO test passes.
  - Foreground sets colflag[hcount] and rowflag[vcount] on the next edge.
  - Out-of-range counts are ignored and never wrap.
- SCAN_H: one column per clock, idx 0..IMG_WIDTH-1. Each flag bit is cleared as it is read.
  - Run start: flag=1, prev=0. Record start=idx.
  - Run end: flag=0, prev=1 gives end=idx-1. A run still open at idx=IMG_WIDTH-1 gives end=IMG_WIDTH-1.
  - Width check: if end-start+1 >= MIN_WIDTH, store into slot seg_cnt if seg_cnt<MAX_SEG; otherwise set overflow and do not store.
- SCAN_V: same scan over the row flags, clearing them.
  - vtop = first set row; vbot = last set row. Both 0 if no row set.
- Internal working registers reset at SCAN_H entry. Public outputs change only in DONE.
  - Slots >= o_seg_cnt read 0.
- Timing: fall sampled at edge T. SCAN_H idx 0 at T+1. SCAN_V idx 0 at T+IMG_WIDTH+1. DONE at T+IMG_WIDTH+IMG_HEIGHT+1, which is also the cycle o_valid=1.
- Outputs hold between DONE pulses.
- Frames overlapping SCAN/DONE/WAIT_VS are ignored.
  - A vs fall during a scan is dropped, with no extra o_valid.
  - After DONE, accumulation restarts only on the next vs rise, so partial frames are never accumulated.
- Flags are fully cleared by the end of SCAN_V, so no init sweep is needed after DONE.
- reset_n low mid-scan: immediate return to reset values, flags cleared, no o_valid.
- Simultaneous rise and fall cannot occur; a fall seen in WAIT_VS is ignored.

Test Plan:
- Default params, single 20x10 foreground box at cols 100..119, rows 50..59 -> one o_valid pulse 1121 cycles after the fall edge; o_seg_cnt=1, seg0=(100,119), o_vtop=50, o_vbot=59, o_overflow=0.
- Boxes at cols 10..19, 30..30, 630..639 with MIN_WIDTH=2 -> o_seg_cnt=2, seg0=(10,19), seg1=(630,639); the run touching the right edge closes at 639.
- Ten 5-column boxes spaced 20 apart from col 20 -> o_seg_cnt=8, segs 0..7 stored, o_overflow=1; next all-background frame -> o_seg_cnt=0, o_overflow=0, vtop=vbot=0, all slots 0.
- Foreground only at hcount<6 or vcount<6, plus hcount=700 -> treated as empty frame, o_seg_cnt=0.
- Second vs fall injected 100 cycles into SCAN_H -> exactly one o_valid; the following complete frame is reported correctly with no residue from the dropped frame.
- reset_n pulsed low mid-SCAN_V -> all outputs 0, no o_valid; the next full frame is reported correctly.
